// File: rtl/prewish_pkg.sv
// prewish_pkg: FSM state encodings, the state type and a clog2 helper
// shared by the prewish debounce bank.
package prewish_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] HOLD  = 2'b01;
    localparam logic [1:0] SPARE = 2'b10;
    localparam logic [1:0] RESP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_HOLD  = HOLD,
        S_SPARE = SPARE,
        S_RESP  = RESP
    } state_t;

    // Bits needed to hold values 0..value-1 (never less than one bit).
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/prewish_db_chan.sv
// prewish_db_chan: one debounced channel.  Two-flop synchroniser, optional
// polarity inversion, then a tick-qualified counter that only accepts a new
// level after STABLE_CNT consecutive differing samples.
// Build option: PREWISH_DEBOUNCE_EDGE_LATCH_EN adds a sticky press bit that
// sets on every accepted release->press transition and clears on i_clr.
module prewish_db_chan
    import prewish_pkg::*;
#(
    parameter int STABLE_CNT = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic i_pad,
    input  logic i_tick,
    input  logic i_clr,
    output logic o_db,
    output logic o_sticky
);

    localparam int            CW   = clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);
    localparam logic          INV  = (ACTIVE_LOW != 0);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          db;
    logic          s;

    assign s    = sync[1] ^ INV;
    assign o_db = db;

    // Bring the asynchronous pad into the clock domain.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) sync <= '0;
        else        sync <= {sync[0], i_pad};
    end

    // Level filter: a differing sample run of STABLE_CNT ticks flips db,
    // any agreeing sample restarts the run.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (i_tick) begin
            if (s == db) begin
                cnt <= '0;
            end else if (cnt >= LAST) begin
                db  <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef PREWISH_DEBOUNCE_EDGE_LATCH_EN
    logic sticky;
    logic rise;

    assign rise     = i_tick && s && !db && (cnt >= LAST);
    assign o_sticky = sticky;

    // Remember presses until read; a press landing on the clear cycle wins.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) sticky <= 1'b0;
        else        sticky <= (sticky & ~i_clr) | rise;
    end
`else
    logic unused_clr;
    assign unused_clr = i_clr;
    assign o_sticky   = 1'b0;
`endif

endmodule

// File: rtl/prewish_debounce_bank.sv
// prewish_debounce_bank: NUM_CH debounced pads served over the STB_I/STB_O
// strobe handshake.  A request captures (masked) state on STB_I rising in
// IDLE; the one-cycle STB_O response follows once STB_I is released.
// Build option: PREWISH_DEBOUNCE_EDGE_LATCH_EN reports latched short presses.
//
//   state | meaning
//   IDLE  | waiting for STB_I; captures DAT_O and toggles o_alive on request
//   HOLD  | request captured, waiting for master to drop STB_I
//   RESP  | STB_O high for this single cycle
//   SPARE | unused encoding, recovers to IDLE
module prewish_debounce_bank
    import prewish_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int TICK_DIV   = 12000,
    parameter int STABLE_CNT = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [NUM_CH-1:0] iN_pads,
    input  logic              STB_I,
    input  logic [NUM_CH-1:0] DAT_I,
    output logic              STB_O,
    output logic [NUM_CH-1:0] DAT_O,
    output logic              o_alive
);

    localparam int PW = clog2(TICK_DIV);

    logic [PW-1:0]     pre;
    logic              tick;
    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] sticky;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] rd_data;
    logic              capture;
    state_t            state;

    assign tick    = (pre == PW'(TICK_DIV - 1));
    assign capture = (state == S_IDLE) && STB_I;
    assign clr     = {NUM_CH{capture}} & DAT_I;

`ifdef PREWISH_DEBOUNCE_EDGE_LATCH_EN
    assign rd_data = db | sticky;
`else
    logic [NUM_CH-1:0] unused_sticky;
    assign unused_sticky = sticky;
    assign rd_data       = db;
`endif

    // Sample-tick prescaler, wraps every TICK_DIV cycles.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I)    pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + PW'(1);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        prewish_db_chan #(
            .STABLE_CNT (STABLE_CNT),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .CLK_I    (CLK_I),
            .RST_I    (RST_I),
            .i_pad    (iN_pads[g]),
            .i_tick   (tick),
            .i_clr    (clr[g]),
            .o_db     (db[g]),
            .o_sticky (sticky[g])
        );
    end

    // Request handshake with registered STB_O, DAT_O and o_alive.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state   <= S_IDLE;
            STB_O   <= 1'b0;
            DAT_O   <= '0;
            o_alive <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    STB_O <= 1'b0;
                    if (STB_I) begin
                        DAT_O   <= rd_data & DAT_I;
                        o_alive <= ~o_alive;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!STB_I) begin
                        STB_O <= 1'b1;
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    STB_O <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    STB_O <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prewish_debounce_bank.sv
// tb_prewish_debounce_bank: directed vectors for the debounce bank with
// TICK_DIV=4, STABLE_CNT=3, NUM_CH=8, active-low pads.
module tb_prewish_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pads = 8'hFF;
    logic       stb_i = 1'b0;
    logic [7:0] dat_i = 8'h00;
    logic       stb_o;
    logic [7:0] dat_o;
    logic       alive;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic exp_alive = 1'b0;

    typedef struct {
        logic [7:0] pads;
        logic [7:0] mask;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];

    prewish_debounce_bank #(
        .NUM_CH     (8),
        .TICK_DIV   (4),
        .STABLE_CNT (3),
        .ACTIVE_LOW (1)
    ) dut (
        .CLK_I   (clk),
        .RST_I   (rst_n),
        .iN_pads (pads),
        .STB_I   (stb_i),
        .DAT_I   (dat_i),
        .STB_O   (stb_o),
        .DAT_O   (dat_o),
        .o_alive (alive)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full read transaction; STB_I is held for hold_cycles edges.
    task automatic do_read(input string name, input logic [7:0] mask, input int hold_cycles,
                           input logic [7:0] exp);
        int         pulses;
        logic [7:0] seen;
        pulses = 0;
        seen   = 'x;
        @(posedge clk);
        #1;
        stb_i = 1'b1;
        dat_i = mask;
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            if (stb_o) pulses++;
        end
        stb_i = 1'b0;
        dat_i = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (stb_o) begin
                pulses++;
                seen = dat_o;
            end
        end
        exp_alive = ~exp_alive;
        check({name, " stb_pulses"}, pulses, 1);
        check({name, " dat_o"}, {24'h0, seen}, {24'h0, exp});
        check({name, " o_alive"}, {31'h0, alive}, {31'h0, exp_alive});
    endtask

    initial begin
        int         pulses;
        logic [7:0] exp_latch;

        vecs[0] = '{pads: 8'hFF, mask: 8'hFF, exp: 8'h00};
        vecs[1] = '{pads: 8'hFE, mask: 8'hFF, exp: 8'h01};
        vecs[2] = '{pads: 8'h7A, mask: 8'h05, exp: 8'h05};
        vecs[3] = '{pads: 8'h7A, mask: 8'h80, exp: 8'h80};
        vecs[4] = '{pads: 8'h00, mask: 8'hFF, exp: 8'hFF};
        vecs[5] = '{pads: 8'h00, mask: 8'h0F, exp: 8'h0F};
        vecs[6] = '{pads: 8'hFF, mask: 8'hFF, exp: 8'h00};

        // Reset state
        cycles(3);
        check("rst stb_o", {31'h0, stb_o}, 32'h0);
        check("rst dat_o", {24'h0, dat_o}, 32'h0);
        check("rst o_alive", {31'h0, alive}, 32'h0);
        rst_n = 1'b1;
        cycles(10);
        check("post-rst stb_o", {31'h0, stb_o}, 32'h0);
        check("post-rst dat_o", {24'h0, dat_o}, 32'h0);
        check("post-rst o_alive", {31'h0, alive}, 32'h0);

        // Table: settle pads, then read with mask
        for (int v = 0; v < 7; v++) begin
            pads = vecs[v].pads;
            cycles(30);
            do_read($sformatf("vec%0d", v), vecs[v].mask, 2, vecs[v].exp);
        end

        // Bounce on pad3: never three consecutive differing ticks
        for (int k = 0; k < 40; k++) begin
            pads[3] = ((k / 6) % 2 == 0) ? 1'b0 : 1'b1;
            cycles(1);
        end
        pads[3] = 1'b1;
        cycles(20);
        do_read("bounce", 8'hFF, 2, 8'h00);

        // Mask with STB_I held 20 cycles: one response only
        pads = 8'h7A;
        cycles(30);
        do_read("hold20", 8'h05, 20, 8'h05);

        // Reset while the FSM sits in HOLD
        @(posedge clk);
        #1;
        stb_i = 1'b1;
        dat_i = 8'hFF;
        cycles(3);
        rst_n = 1'b0;
        #1;
        check("midrst dat_o", {24'h0, dat_o}, 32'h0);
        check("midrst o_alive", {31'h0, alive}, 32'h0);
        stb_i = 1'b0;
        dat_i = 8'h00;
        cycles(2);
        rst_n = 1'b1;
        exp_alive = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (stb_o) pulses++;
        end
        check("midrst no_stb", pulses, 0);
        cycles(30);
        do_read("after_rst", 8'hFF, 2, 8'h85);

        // Short press between polls
        pads = 8'hFF;
        cycles(30);
        do_read("latch_pre", 8'hFF, 2, 8'h00);
        pads[1] = 1'b0;
        cycles(80);
        pads[1] = 1'b1;
        cycles(30);
`ifdef PREWISH_DEBOUNCE_EDGE_LATCH_EN
        exp_latch = 8'h02;
`else
        exp_latch = 8'h00;
`endif
        do_read("latch_first", 8'hFF, 2, exp_latch);
        do_read("latch_second", 8'hFF, 2, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
